// File: rtl/number_analyzer_p_if.sv
// Request/result bundle for the number analyser: operand and enable mask
// in, status and result flags out.
interface number_analyzer_p_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic             go_i;
   logic [WIDTH-1:0] inp;
   logic [2:0]       test_en;
   logic             busy;
   logic             done_o;
   logic             isEven;
   logic             isFibonacci;
   logic             isPalindrome;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] cycles_o;

   // Requester side: issues operands and watches results.
   modport master (
      output go_i, inp, test_en,
      input  busy, done_o, isEven, isFibonacci, isPalindrome, state_o, cycles_o
   );

   // Analyser side: accepts operands and publishes results.
   modport slave (
      input  go_i, inp, test_en,
      output busy, done_o, isEven, isFibonacci, isPalindrome, state_o, cycles_o
   );
endinterface

// File: rtl/number_analyzer_p.sv
// Parametrised number analyser. A single accepted operand is classified as
// even, Fibonacci member and binary palindrome. The even test is settled
// at acceptance; the other two run as independent iterative engines that
// advance once per RUN cycle and freeze when finished. The FSM leaves RUN
// on the cycle both engines report completion.
module number_analyzer_p #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         reset,
   number_analyzer_p_if.slave bus
);

   // Fibonacci accumulators carry two guard bits so that a term overshooting
   // the largest WIDTH-bit value still compares as greater, not wrapped.
   localparam int AW = WIDTH + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] x;
   logic             en_fib;
   logic             en_pal;

   logic [AW-1:0]    fib_a;
   logic [AW-1:0]    fib_b;
   logic             fib_done;

   logic [WIDTH-1:0] pal_t;
   logic [WIDTH-1:0] pal_r;
   logic             pal_done;

   logic [CNT_W-1:0] cnt;
   logic             is_even;
   logic             is_fib;
   logic             is_pal;

   logic             accept;
   logic             in_run;
   logic [AW-1:0]    x_ext;
   logic             fib_hit;
   logic             fib_over;
   logic             fib_fin;
   logic             pal_empty;
   logic             pal_fin;
   logic             all_fin;

   // Saturating increment: the counter sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] one;
      one = {{(CNT_W-1){1'b0}}, 1'b1};
      return (v == {CNT_W{1'b1}}) ? v : v + one;
   endfunction

   // One bit-reversal step: the LSB of t is appended to r.
   function automatic logic [WIDTH-1:0] rev_push(input logic [WIDTH-1:0] r_in,
                                                 input logic             bit_in);
      return {r_in[WIDTH-2:0], bit_in};
   endfunction

   assign accept    = (state_q == ST_IDLE) && bus.go_i;
   assign in_run    = (state_q == ST_RUN);
   assign x_ext     = {2'b00, x};
   assign fib_hit   = (fib_a == x_ext);
   assign fib_over  = (fib_a > x_ext);
   assign pal_empty = (pal_t == '0);

   // An engine counts as finished on the edge where it resolves, so the FSM
   // can leave RUN on the same edge the last flag is written.
   assign fib_fin = fib_done | ~en_fib | fib_hit | fib_over;
   assign pal_fin = pal_done | ~en_pal | pal_empty;
   assign all_fin = fib_fin & pal_fin;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; go_i is only looked at in IDLE, so requests while
   // busy or in the DONE cycle are dropped rather than queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.go_i) state_d = ST_RUN;
         ST_RUN:  if (all_fin)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture, even flag and RUN-cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         x       <= '0;
         en_fib  <= 1'b0;
         en_pal  <= 1'b0;
         is_even <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         x       <= bus.inp;
         en_fib  <= bus.test_en[1];
         en_pal  <= bus.test_en[2];
         is_even <= bus.test_en[0] & ~bus.inp[0];
         cnt     <= '0;
      end else if (in_run) begin
         cnt     <= sat_inc(cnt);
      end
   end

   // Fibonacci engine: walk a,b along the sequence until a meets or passes x.
   always_ff @(posedge clk) begin
      if (reset) begin
         fib_a    <= '0;
         fib_b    <= '0;
         fib_done <= 1'b0;
         is_fib   <= 1'b0;
      end else if (accept) begin
         fib_a    <= '0;
         fib_b    <= {{(AW-1){1'b0}}, 1'b1};
         fib_done <= 1'b0;
         is_fib   <= 1'b0;
      end else if (in_run && !fib_done) begin
         if (!en_fib) begin
            fib_done <= 1'b1;
            is_fib   <= 1'b0;
         end else if (fib_hit) begin
            fib_done <= 1'b1;
            is_fib   <= 1'b1;
         end else if (fib_over) begin
            fib_done <= 1'b1;
            is_fib   <= 1'b0;
         end else begin
            fib_a    <= fib_b;
            fib_b    <= fib_a + fib_b;
         end
      end
   end

   // Palindrome engine: shift x out LSB-first into r until nothing is left;
   // leading zeros never enter r, so only significant bits are compared.
   always_ff @(posedge clk) begin
      if (reset) begin
         pal_t    <= '0;
         pal_r    <= '0;
         pal_done <= 1'b0;
         is_pal   <= 1'b0;
      end else if (accept) begin
         pal_t    <= bus.inp;
         pal_r    <= '0;
         pal_done <= 1'b0;
         is_pal   <= 1'b0;
      end else if (in_run && !pal_done) begin
         if (!en_pal) begin
            pal_done <= 1'b1;
            is_pal   <= 1'b0;
         end else if (pal_empty) begin
            pal_done <= 1'b1;
            is_pal   <= (pal_r == x);
         end else begin
            pal_r    <= rev_push(pal_r, pal_t[0]);
            pal_t    <= pal_t >> 1;
         end
      end
   end

   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done_o       = (state_q == ST_DONE);
   assign bus.state_o      = state_q;
   assign bus.cycles_o     = cnt;
   assign bus.isEven       = is_even;
   assign bus.isFibonacci  = is_fib;
   assign bus.isPalindrome = is_pal;

endmodule

// File: tb/tb_number_analyzer_p.sv
// Self-checking bench for number_analyzer_p at WIDTH=32, CNT_W=8.
module tb_number_analyzer_p;

   localparam int WIDTH = 32;
   localparam int CNT_W = 8;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   number_analyzer_p_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   number_analyzer_p #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: flags and evaluation count from the arithmetic definitions.
   function automatic void model(input logic [31:0] x, input logic [2:0] en,
                                 output bit ev, output bit fib, output bit pal,
                                 output int n);
      longint unsigned a, b, tmp;
      int fe, pe, nb;
      ev = en[0] && (x % 2 == 0);
      if (en[1]) begin
         a = 0; b = 1; fe = 1;
         while (a < longint'(x)) begin
            tmp = a + b; a = b; b = tmp; fe++;
         end
         fib = (a == longint'(x));
      end else begin
         fib = 0; fe = 1;
      end
      if (en[2]) begin
         nb = 0;
         for (int i = 0; i < 32; i++) if (x[i]) nb = i + 1;
         pal = 1;
         for (int i = 0; i < nb; i++) if (x[i] != x[nb-1-i]) pal = 0;
         pe = nb + 1;
      end else begin
         pal = 0; pe = 1;
      end
      n = (fe > pe) ? fe : pe;
   endfunction

   task automatic run_op(input logic [31:0] x, input logic [2:0] en, input bit poke);
      bit ev, fib, pal;
      int n, edges, expc;
      model(x, en, ev, fib, pal, n);
      expc = (n > 255) ? 255 : n;
      @(negedge clk);
      bus.inp = x; bus.test_en = en; bus.go_i = 1'b1;
      @(posedge clk); edges = 1;
      @(negedge clk);
      bus.go_i = 1'b0;
      chk("acc_busy",   bus.busy, 1);
      chk("acc_fibclr", bus.isFibonacci, 0);
      chk("acc_palclr", bus.isPalindrome, 0);
      chk("acc_cycclr", bus.cycles_o, 0);
      chk("acc_even",   bus.isEven, ev);
      while (!bus.done_o && edges < 200) begin
         if (poke && edges == 3) begin
            bus.go_i = 1'b1; bus.inp = $urandom; bus.test_en = 3'($urandom_range(0, 7));
         end else begin
            bus.go_i = 1'b0;
         end
         @(posedge clk); edges++;
         @(negedge clk);
      end
      bus.go_i = 1'b0;
      chk("done_seen", bus.done_o, 1);
      chk("latency",   edges, n + 1);
      chk("done_state", bus.state_o, 2);
      chk("done_busy", bus.busy, 1);
      chk("even",      bus.isEven, ev);
      chk("fib",       bus.isFibonacci, fib);
      chk("pal",       bus.isPalindrome, pal);
      chk("cycles",    bus.cycles_o, expc);
      // go during the DONE cycle must not start a new run
      bus.go_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.go_i = 1'b0;
      chk("post_state", bus.state_o, 0);
      chk("post_done",  bus.done_o, 0);
      chk("hold_fib",   bus.isFibonacci, fib);
      chk("hold_pal",   bus.isPalindrome, pal);
      chk("hold_even",  bus.isEven, ev);
      chk("hold_cyc",   bus.cycles_o, expc);
   endtask

   initial begin
      logic [31:0] rx;
      tests = 0; fails = 0;
      bus.go_i = 1'b0; bus.inp = '0; bus.test_en = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", bus.state_o, 0);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done_o, 0);
      chk("rst_even",  bus.isEven, 0);
      chk("rst_fib",   bus.isFibonacci, 0);
      chk("rst_pal",   bus.isPalindrome, 0);
      chk("rst_cyc",   bus.cycles_o, 0);
      reset = 1'b0;

      run_op(32'd0, 3'b111, 0);
      run_op(32'd5, 3'b111, 0);
      run_op(32'd6, 3'b111, 1);
      run_op(32'hFFFF_FFFF, 3'b111, 1);
      run_op(32'd8, 3'b001, 0);
      run_op(32'd21, 3'b110, 1);

      // Reset in the middle of a long run abandons it.
      @(negedge clk);
      bus.inp = 32'hFFFF_FFFF; bus.test_en = 3'b111; bus.go_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.go_i = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_cyc", bus.cycles_o, 9);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("mrst_state", bus.state_o, 0);
      chk("mrst_busy",  bus.busy, 0);
      chk("mrst_done",  bus.done_o, 0);
      chk("mrst_even",  bus.isEven, 0);
      chk("mrst_fib",   bus.isFibonacci, 0);
      chk("mrst_pal",   bus.isPalindrome, 0);
      chk("mrst_cyc",   bus.cycles_o, 0);
      reset = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk("mrst_nodone", bus.done_o, 0);
      end

      run_op(32'd13, 3'b111, 0);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0) rx = $urandom;
         else                           rx = 32'($urandom_range(0, 400));
         run_op(rx, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
